// File: rtl/albacore_bus_responder.sv
// Albacore bus responder: word-addressed RAM plus a memory-mapped 16-bit
// Galois LFSR peripheral (SEED / CTRL / STATE / COUNT) at 0xFF00..0xFF03.
// Reads are registered (one-cycle latency); writes land on the sampling edge.
module albacore_bus_responder #(
  parameter int          RAM_DEPTH = 4096,
  parameter logic [15:0] LFSR_TAPS = 16'hB400,
  parameter logic [15:0] SEED_INIT = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [15:0] rdata_o,
  output logic [15:0] lfsr_out_o
);

  localparam int          AW     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [15:0] A_SEED = 16'hFF00;
  localparam logic [15:0] A_CTRL = 16'hFF01;
  localparam logic [15:0] A_STAT = 16'hFF02;
  localparam logic [15:0] A_CNT  = 16'hFF03;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
  } req_t;

  req_t req;
  assign req = '{addr: addr_i, wdata: wdata_i, we: we_i, re: re_i};

  logic [15:0] mem [RAM_DEPTH];

  logic [15:0] state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        run_q,   run_d;
  logic [15:0] rdata_q, rdata_d;

  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic          seed_wr, ctrl_wr, step, advance;
  logic [15:0]   rd_val;
  logic [15:0]   lfsr_next;

  assign ram_hit = ({16'h0000, req.addr} < 32'(RAM_DEPTH));
  assign ram_idx = req.addr[AW-1:0];
  assign seed_wr = req.we && (req.addr == A_SEED);
  assign ctrl_wr = req.we && (req.addr == A_CTRL);
  assign step    = ctrl_wr && req.wdata[1];
  // A seed load wins the edge outright: no shift and no count bump.
  assign advance = (run_q || step) && !seed_wr;
  assign lfsr_next = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : 16'h0000);

  // Read mux sees registered state, so STATE/COUNT/RAM reads return pre-edge values.
  always_comb begin
    rd_val = 16'h0000;
    if (ram_hit) begin
      rd_val = mem[ram_idx];
    end else begin
      case (req.addr)
        A_CTRL:  rd_val = {15'h0000, run_q};
        A_STAT:  rd_val = state_q;
        A_CNT:   rd_val = count_q;
        default: rd_val = 16'h0000;
      endcase
    end
  end

  // Next-state for the LFSR peripheral and the read register.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    run_d   = run_q;
    rdata_d = rdata_q;
    if (req.re) rdata_d = rd_val;
    if (seed_wr) begin
      // Zero is the Galois lock-up state; substitute 1 instead.
      state_d = (req.wdata == 16'h0000) ? 16'h0001 : req.wdata;
    end else if (advance) begin
      state_d = lfsr_next;
      count_d = count_q + 16'h0001;
    end
    if (ctrl_wr) run_d = req.wdata[0];
  end

  // Peripheral and read-data registers; reset beats every strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED_INIT;
      count_q <= 16'h0000;
      run_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      run_q   <= run_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM write port; contents survive reset, but writes during reset are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && req.we && ram_hit) mem[ram_idx] <= req.wdata;
  end

  assign rdata_o    = rdata_q;
  assign lfsr_out_o = state_q;

endmodule

// File: tb/tb_albacore_bus_responder.sv
// Bench for albacore_bus_responder: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_albacore_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic        we = 1'b0, re = 1'b0;
  logic [15:0] rdata, lfsr_out;

  int n_chk  = 0;
  int n_fail = 0;

  albacore_bus_responder #(.RAM_DEPTH(4096), .LFSR_TAPS(16'hB400), .SEED_INIT(16'hACE1)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata),
    .we_i(we), .re_i(re), .rdata_o(rdata), .lfsr_out_o(lfsr_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] mram [4096];
  bit          mwr  [4096];
  logic [15:0] m_state, m_count, m_rdata;
  bit          m_run, m_known, chk_en;

  function automatic logic [15:0] galois(input logic [15:0] s);
    logic [15:0] n;
    n = s / 2;
    if (s % 2 == 1) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [15:0] mread(input logic [15:0] a);
    if (a < 4096) return mram[a];
    if (a == 16'hFF01) return {15'd0, m_run};
    if (a == 16'hFF02) return m_state;
    if (a == 16'hFF03) return m_count;
    return 16'h0000;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mwr[i] = 0;
    chk_en = 0; m_known = 0; m_run = 0;
    m_state = 16'hACE1; m_count = 0; m_rdata = 0;
  end

  // Model update at each edge from the inputs held stable across it, then compare.
  always @(posedge clk) begin
    bit do_adv;
    if (rst) begin
      m_rdata = 0; m_known = 1; m_state = 16'hACE1; m_count = 0; m_run = 0;
      chk_en = 1;
    end else begin
      if (re) begin
        m_rdata = mread(addr);
        m_known = (addr >= 4096) || mwr[addr];
      end
      do_adv = m_run || (we && addr == 16'hFF01 && wdata[1]);
      if (we && addr == 16'hFF00) m_state = (wdata == 0) ? 16'h0001 : wdata;
      else if (do_adv) begin
        m_state = galois(m_state);
        m_count = m_count + 1;
      end
      if (we && addr == 16'hFF01) m_run = wdata[0];
      if (we && addr < 4096) begin
        mram[addr] = wdata;
        mwr[addr]  = 1;
      end
    end
    #1;
    if (chk_en) begin
      check("lfsr_out", lfsr_out, m_state);
      if (m_known) check("rdata", rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic r, input logic [15:0] a, input logic [15:0] d,
                     input logic w, input logic rd);
    @(negedge clk);
    rst = r; addr = a; wdata = d; we = w; re = rd;
    @(posedge clk);
    #2;
    rst = 0; we = 0; re = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 16'h0000, 16'h0000, 0, 0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d); cyc(0, a, d, 1, 0); endtask
  task automatic rd(input logic [15:0] a); cyc(0, a, 16'h0000, 0, 1); endtask

  logic [15:0] c1, c2;

  initial begin
    // 1. Reset
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("reset_rdata", rdata, 16'h0000);
    check("reset_lfsr", lfsr_out, 16'hACE1);
    rd(16'hFF03);
    check("reset_count", rdata, 16'h0000);

    // 2. RAM
    wr(16'h0010, 16'h1234);
    rd(16'h0010);
    check("ram_rd", rdata, 16'h1234);
    rd(16'h8000);
    check("unmapped_rd", rdata, 16'h0000);
    cyc(0, 16'h0010, 16'h5555, 1, 1);
    check("rbw_old", rdata, 16'h1234);
    rd(16'h0010);
    check("rbw_new", rdata, 16'h5555);
    rd(16'hFF00);
    check("seed_reads0", rdata, 16'h0000);

    // 3. Single steps
    wr(16'hFF01, 16'h0002);
    check("step1_lfsr", lfsr_out, 16'hE270);
    rd(16'hFF03);
    check("step1_count", rdata, 16'h0001);
    wr(16'hFF01, 16'h0002);
    check("step2_lfsr", lfsr_out, 16'h7138);
    rd(16'hFF03);
    check("step2_count", rdata, 16'h0002);
    rd(16'hFF01);
    check("ctrl_rd", rdata, 16'h0000);

    // 4. Run mode: run_q is 1 for the 10 idle edges and the stopping write edge
    wr(16'hFF01, 16'h0001);
    idle(10);
    wr(16'hFF01, 16'h0000);
    rd(16'hFF03);
    check("run_count", rdata, 16'd13);
    rd(16'hFF02);
    check("run_state", rdata, lfsr_out);

    // 5. Seed edge cases
    wr(16'hFF00, 16'h0000);
    check("seed0", lfsr_out, 16'h0001);
    wr(16'hFF01, 16'h0001);
    rd(16'hFF03);
    c1 = rdata;
    wr(16'hFF00, 16'hBEEF);
    check("seed_run", lfsr_out, 16'hBEEF);
    rd(16'hFF03);
    c2 = rdata;
    check("seed_no_count", c2 - c1, 16'h0001);

    // 6. Reset mid-run with a read in flight
    cyc(1, 16'hFF02, 16'h0000, 0, 1);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_lfsr", lfsr_out, 16'hACE1);
    idle(3);
    check("rst_run_off", lfsr_out, 16'hACE1);
    rd(16'hFF03);
    check("rst_count", rdata, 16'h0000);

    // Random traffic, checked by the per-cycle model compare
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 4))
        0:       a = 16'($urandom_range(0, 31));
        1:       a = 16'hFF00 + 16'($urandom_range(0, 4));
        2:       a = 16'($urandom);
        3:       a = 16'hFF01;
        default: a = 16'hFF03;
      endcase
      cyc(($urandom_range(0, 59) == 0), a,
          ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/albacore_bus_responder.md
Name: albacore_bus_responder

Overview:
Memory-side responder for the Albacore CPU bus. It answers the datapath's address/write-data outputs and returns read data on the CPU's din.
- Backs a word-addressed program/data RAM.
- Hosts a memory-mapped 16-bit Galois LFSR peripheral: seed, control, state and step counter.
- Sits between the CPU datapath/controller and the top level, replacing a bare RAM.

Parameters:
RAM_DEPTH, 4096, number of 16-bit RAM words at addresses 0x0000..RAM_DEPTH-1; maximum 0xFF00.
LFSR_TAPS, 16'hB400, Galois feedback mask XORed into the state when the shifted-out bit is 1.
SEED_INIT, 16'hACE1, LFSR state after reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
addr  input  16  word address from the CPU.
wdata  input  16  write data; CPU dout.
we  input  1  write strobe, one cycle per write.
re  input  1  read strobe, one cycle per read.
rdata  output  16  read data to the CPU din; registered.
lfsr_out  output  16  current LFSR state, for top-level observation.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - rdata=0, LFSR state=SEED_INIT, COUNT=0, CTRL.run=0, so lfsr_out=SEED_INIT.
  - RAM contents are not reset.
  - rst has priority over every other input in the same cycle; an in-flight read is discarded and rdata=0.
- Address map:
  - 0x0000..RAM_DEPTH-1: RAM, read/write.
  - 0xFF00 SEED: write-only. Loads the state; a write of 0 loads 16'h0001 (no lock-up state). Reads return 0.
  - 0xFF01 CTRL: bit0 run (R/W); bit1 step (write-only, self-clearing, reads 0); bits 15:2 read 0.
  - 0xFF02 STATE: read-only current state.
  - 0xFF03 COUNT: read-only 16-bit advance counter, wraps 0xFFFF->0x0000.
  - Any other address: reads return 0, writes are ignored.
- Read latency:
  - re sampled at edge N; rdata carries the addressed value after edge N (valid in cycle N+1).
  - rdata holds its value until the next re or rst.
- Write:
  - we sampled at edge N; the target is updated at edge N.
  - re and we in the same cycle to the same address: read returns the pre-write value (read-before-write). The write still occurs.
- LFSR advance:
  - Advance condition at an edge: (CTRL.run==1) OR (a CTRL write with wdata[1]==1 this cycle).
  - Advance computes next = (state>>1) XOR (state[0] ? LFSR_TAPS : 0), and COUNT increments by 1.
  - The run-bit value written in a cycle does not take effect until the following edge. A step write during run still produces only one advance that edge.
- Priority within one edge: SEED write > advance.
  - A SEED write during run loads the seed and no advance occurs that edge.
  - COUNT does not increment on that edge; a SEED write does not clear COUNT.
- Snapshot rules:
  - A read of STATE or COUNT returns the value before that edge's update.
  - lfsr_out always reflects the current registered state.
- No back-pressure: the responder accepts every strobe and has no ready/wait signal.

Test Plan:
1. Reset: assert rst for 2 cycles, then release -> rdata=0x0000, lfsr_out=0xACE1; read 0xFF03 -> 0x0000.
2. RAM: write 0x1234 to 0x0010, then read 0x0010 -> rdata=0x1234 one cycle after re. Read 0x8000 (with RAM_DEPTH=4096) -> 0x0000. Same-cycle re+we of 0x5555 to 0x0010 -> rdata=0x1234, and a later read -> 0x5555.
3. Single step from reset: write CTRL=0x0002 -> lfsr_out=0xE270, COUNT=1. Step again -> 0x7138, COUNT=2. Read CTRL -> 0x0000.
4. Run mode: write CTRL=0x0001, wait 10 cycles, write CTRL=0x0000 -> COUNT equals the number of edges with run=1, and the state matches the software Galois model.
5. Seed edge cases: write SEED=0x0000 -> lfsr_out=0x0001. During run, write SEED=0xBEEF -> lfsr_out=0xBEEF that cycle, with COUNT unchanged at that edge.
6. Reset mid-run: with run=1 and a pending re, assert rst -> rdata=0, lfsr_out=0xACE1, COUNT=0, and run stays 0 after release.
